fft_peak_detect: RTL

- Sits directly downstream of the FFT magnitude stage (data_modulus) in fft_top. It consumes the per-bin magnitude stream (fft_data / fft_valid / fft_eop).
- For each FFT frame it finds the bin with the largest magnitude inside a configurable search window, then reports bin index, magnitude and a threshold verdict.
- Frame-length errors (early or missing eop) are detected and flagged.
- Output feeds the PID/measurement logic and the host readout.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_peak_detect.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and window helper for the FFT peak detector.
// Everything downstream of the FFT magnitude stage imports this package.
package fft_pkg;

    localparam int FFT_N = 1024;
    localparam int BIN_W = $clog2(FFT_N);
    localparam int MAG_W = 32;

    localparam int DC_SKIP_DEF   = 2;
    localparam bit HALF_ONLY_DEF = 1'b1;

    typedef logic [BIN_W-1:0] bin_t;
    typedef logic [MAG_W-1:0] mag_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        bin_t bin;
        mag_t mag;
    } best_t;

    localparam bin_t LAST_BIN = bin_t'(FFT_N - 1);

    // A real-valued input gives a mirrored spectrum, so only the lower half is searched.
    function automatic bin_t win_hi(input bit half_only);
        return half_only ? bin_t'(FFT_N / 2 - 1) : LAST_BIN;
    endfunction

endpackage

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over the FFT magnitude stream with threshold verdict
// and frame-length error detection.
//
// state | meaning
// IDLE  | between frames; the next valid beat is bin 0
// SCAN  | inside a frame; counting bins and tracking the running best
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int DC_SKIP   = DC_SKIP_DEF,
    parameter bit HALF_ONLY = HALF_ONLY_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [MAG_W-1:0] fft_data,
    input  logic             fft_valid,
    input  logic             fft_eop,
    input  logic [MAG_W-1:0] threshold,
    output logic [BIN_W-1:0] peak_bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic             peak_found,
    output logic             peak_valid,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam best_t BEST_INIT = '{bin: bin_t'(DC_SKIP), mag: '0};

    state_t state;
    state_t state_nxt;
    bin_t   bin_cnt;
    logic   last_beat;
    logic   first_beat;
    logic   close_good;
    logic   close_err;
    logic   in_win;
    best_t  best;
    best_t  best_base;
    best_t  best_nxt;
    mag_t   thr_lat;
    mag_t   thr_eff;

    assign last_beat = (bin_cnt == LAST_BIN);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fft_valid && !(fft_eop || last_beat)) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (fft_valid && (fft_eop || last_beat)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A missing eop on the last bin closes the frame just like an early eop.
    always_comb begin
        first_beat = 1'b0;
        close_good = 1'b0;
        close_err  = 1'b0;
        if (fft_valid) begin
            first_beat = (state == IDLE);
            if (fft_eop || last_beat) begin
                close_good = fft_eop && last_beat;
                close_err  = !(fft_eop && last_beat);
            end
        end
    end

    assign in_win = (bin_cnt >= bin_t'(DC_SKIP)) && (bin_cnt <= win_hi(HALF_ONLY));

    // Bin 0 starts from a fresh best so the close beat and the next frame's
    // first beat can be back-to-back without a flush cycle.
    always_comb begin
        best_base = first_beat ? BEST_INIT : best;
        best_nxt  = best_base;
        if (fft_valid && in_win && (fft_data > best_base.mag)) begin
            best_nxt = '{bin: bin_cnt, mag: fft_data};
        end
        thr_eff = first_beat ? threshold : thr_lat;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bin_cnt <= '0;
            best    <= BEST_INIT;
            thr_lat <= '0;
        end else if (fft_valid) begin
            if (close_good || close_err) begin
                bin_cnt <= '0;
                best    <= BEST_INIT;
            end else begin
                bin_cnt <= bin_cnt + bin_t'(1);
                best    <= best_nxt;
            end
            if (first_beat) begin
                thr_lat <= threshold;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_found <= 1'b0;
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            peak_valid <= close_good;
            frame_err  <= close_err;
            if (close_good) begin
                peak_bin   <= best_nxt.bin;
                peak_mag   <= best_nxt.mag;
                peak_found <= (best_nxt.mag >= thr_eff);
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
